// File: rtl/ro_puf_eval.sv
// ro_puf_eval: ring-oscillator PUF evaluation engine comparing challenge-selected oscillator pairs
// Ports:
//   clk, rst_n          clock; asynchronous active-high reset
//   start               evaluation request, sampled in IDLE only
//   challenge, window   base oscillator index and count-window length, captured on start
//   ro_in               raw oscillator outputs, asynchronous to clk
//   ro_en               enables for the pair under evaluation
//   busy, resp_valid    evaluation in progress; one-cycle completion pulse
//   resp, tie           per-bit response and equal-count flag
//   count_a, count_b    raw pair counts from the most recent compare
module ro_puf_eval #(
   parameter int NUM_RO     = 16,
   parameter int SEL_W      = 4,
   parameter int CNT_W      = 12,
   parameter int WIN_W      = 10,
   parameter int SETTLE_CYC = 4,
   parameter int RESP_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [SEL_W-1:0]     challenge,
   input  logic [WIN_W-1:0]     window,
   input  logic [NUM_RO-1:0]    ro_in,
   output logic [NUM_RO-1:0]    ro_en,
   output logic                 busy,
   output logic                 resp_valid,
   output logic [RESP_BITS-1:0] resp,
   output logic [RESP_BITS-1:0] tie,
   output logic [CNT_W-1:0]     count_a,
   output logic [CNT_W-1:0]     count_b
);
   localparam int KW = RESP_BITS > 1 ? $clog2(RESP_BITS) : 1;
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int CW = WIN_W > SW ? WIN_W : SW;
   typedef enum logic [2:0] {IDLE, SETTLE, COUNT, COMPARE, DONE} state_t;
   state_t state, state_nx;
   logic [NUM_RO-1:0] s1, s2, s3, ev;
   logic [SEL_W-1:0] chal, a, b;
   logic [WIN_W-1:0] win;
   logic [KW-1:0] k;
   logic [CW-1:0] cyc, win_last;
   logic [CNT_W-1:0] cnt_a, cnt_b;
   logic [RESP_BITS-1:0] bit_k;
   logic last_cyc, last_bit;
   // pair indices wrap naturally in SEL_W bits
   assign a = chal + SEL_W'({k, 1'b0});
   assign b = a + SEL_W'(1);
   assign ev = s2 & ~s3;
   // a window of 0 runs for one cycle, same as 1
   assign win_last = (win == '0) ? '0 : CW'(win) - CW'(1);
   assign last_cyc = (state == SETTLE) ? (cyc == CW'(SETTLE_CYC - 1)) : (cyc == win_last);
   assign last_bit = (k == KW'(RESP_BITS - 1));
   assign bit_k = RESP_BITS'(1) << k;
   assign busy = (state != IDLE);
   assign resp_valid = (state == DONE);
   assign ro_en = (state == SETTLE || state == COUNT) ? ((NUM_RO'(1) << a) | (NUM_RO'(1) << b)) : '0;
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= ro_in;
         s2 <= s1;
         s3 <= s2;
      end
   end
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? SETTLE : IDLE;
         SETTLE:  state_nx = last_cyc ? COUNT : SETTLE;
         COUNT:   state_nx = last_cyc ? COMPARE : COUNT;
         COMPARE: state_nx = last_bit ? DONE : SETTLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         chal    <= '0;
         win     <= '0;
         k       <= '0;
         cyc     <= '0;
         cnt_a   <= '0;
         cnt_b   <= '0;
         resp    <= '0;
         tie     <= '0;
         count_a <= '0;
         count_b <= '0;
      end else begin
         cyc <= (state != state_nx) ? '0 : cyc + CW'(1);
         case (state)
            IDLE: if (start) begin
               chal  <= challenge;
               win   <= window;
               k     <= '0;
               cnt_a <= '0;
               cnt_b <= '0;
            end
            COUNT: begin
               if (ev[a] && cnt_a != '1) cnt_a <= cnt_a + CNT_W'(1);
               if (ev[b] && cnt_b != '1) cnt_b <= cnt_b + CNT_W'(1);
            end
            COMPARE: begin
               resp    <= (resp & ~bit_k) | ((cnt_a > cnt_b) ? bit_k : '0);
               tie     <= (tie & ~bit_k) | ((cnt_a == cnt_b) ? bit_k : '0);
               count_a <= cnt_a;
               count_b <= cnt_b;
               cnt_a   <= '0;
               cnt_b   <= '0;
               if (!last_bit) k <= k + KW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ro_puf_eval.sv
// tb_ro_puf_eval: directed self-checking bench for ro_puf_eval
module tb_ro_puf_eval;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [2:0] st = '0;
   logic [2:0] challenge = '0;
   logic [9:0] window = '0;
   logic [7:0] ro = '0;
   int per [8];
   int tick = 0;
   int sel = 0;
   int pass_n = 0;
   int total_n = 0;
   logic v1, v4, v8, b1, b4, b8;
   logic [7:0] en1, en4, en8;
   logic [0:0] r1, t1;
   logic [3:0] r4, t4;
   logic [7:0] r8, t8;
   logic [3:0] ca1, cb1;
   logic [11:0] ca4, cb4, ca8, cb8;
   logic cv, cb;
   logic [7:0] cen;
   ro_puf_eval #(.NUM_RO(8), .SEL_W(3), .CNT_W(4), .WIN_W(10), .SETTLE_CYC(4), .RESP_BITS(1)) d1 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .challenge(challenge), .window(window), .ro_in(ro),
      .ro_en(en1), .busy(b1), .resp_valid(v1), .resp(r1), .tie(t1), .count_a(ca1), .count_b(cb1));
   ro_puf_eval #(.NUM_RO(8), .SEL_W(3), .CNT_W(12), .WIN_W(10), .SETTLE_CYC(4), .RESP_BITS(4)) d4 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .challenge(challenge), .window(window), .ro_in(ro),
      .ro_en(en4), .busy(b4), .resp_valid(v4), .resp(r4), .tie(t4), .count_a(ca4), .count_b(cb4));
   ro_puf_eval #(.NUM_RO(8), .SEL_W(3), .CNT_W(12), .WIN_W(10), .SETTLE_CYC(4), .RESP_BITS(8)) d8 (
      .clk(clk), .rst_n(rst_n), .start(st[2]), .challenge(challenge), .window(window), .ro_in(ro),
      .ro_en(en8), .busy(b8), .resp_valid(v8), .resp(r8), .tie(t8), .count_a(ca8), .count_b(cb8));
   assign cv  = sel == 0 ? v1 : sel == 1 ? v4 : v8;
   assign cb  = sel == 0 ? b1 : sel == 1 ? b4 : b8;
   assign cen = sel == 0 ? en1 : sel == 1 ? en4 : en8;
   always #5 clk = ~clk;
   // square-wave oscillators, per[i] clk cycles per period, 0 = stopped
   always @(negedge clk) begin
      tick = tick + 1;
      for (int i = 0; i < 8; i++) ro[i] = (per[i] > 1) && ((tick % per[i]) < per[i] / 2);
   end
   task automatic set_per(input int p0, p1, p2, p3, p4, p5, p6, p7);
      per[0] = p0; per[1] = p1; per[2] = p2; per[3] = p3;
      per[4] = p4; per[5] = p5; per[6] = p6; per[7] = p7;
   endtask
   // cycle n is the n-th negedge after the edge that samples start
   task automatic run_eval(input int s, input logic [2:0] ch, input logic [9:0] w, input int mid,
                           output int lat, output int nv, output logic bsy_after,
                           output logic [7:0] en_s, output logic [7:0] en_c);
      sel = s;
      lat = -1;
      nv = 0;
      bsy_after = 1'bx;
      en_s = 'x;
      en_c = 'x;
      @(negedge clk);
      challenge = ch;
      window = w;
      st[s] = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 3000; c++) begin
         @(negedge clk);
         st[s] = (c == mid);
         if (c == 2) en_s = cen;
         if (c == 10) en_c = cen;
         if (cv === 1'b1) begin
            nv++;
            if (lat < 0) lat = c;
         end
         if (lat >= 0 && c == lat + 1) bsy_after = cb;
         if (lat >= 0 && c == lat + 8) break;
      end
      st[s] = 1'b0;
   endtask
   task automatic test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      total_n++;
      if ({b1, v1, en1, r1, t1, ca1, cb1} !== '0) $display("FAIL reset_d1 got %h want 0", {b1, v1, en1, r1, t1, ca1, cb1});
      else pass_n++;
      total_n++;
      if ({b4, v4, en4, r4, t4, ca4, cb4} !== '0) $display("FAIL reset_d4 got %h want 0", {b4, v4, en4, r4, t4, ca4, cb4});
      else pass_n++;
      total_n++;
      if ({b8, v8, en8, r8, t8, ca8, cb8} !== '0) $display("FAIL reset_d8 got %h want 0", {b8, v8, en8, r8, t8, ca8, cb8});
      else pass_n++;
   endtask
   task automatic test_single_bit;
      int lat, nv;
      logic ba;
      logic [7:0] es, ec;
      set_per(0, 0, 4, 8, 0, 0, 0, 0);
      run_eval(0, 3'd2, 10'd16, 0, lat, nv, ba, es, ec);
      total_n++;
      if (lat !== 22) $display("FAIL single_latency got %0d want 22", lat);
      else pass_n++;
      total_n++;
      if (es !== 8'b0000_1100) $display("FAIL single_en_settle got %b want 00001100", es);
      else pass_n++;
      total_n++;
      if (ec !== 8'b0000_1100) $display("FAIL single_en_count got %b want 00001100", ec);
      else pass_n++;
      total_n++;
      if (ca1 < 3 || ca1 > 5) $display("FAIL single_count_a got %0d want 4+-1", ca1);
      else pass_n++;
      total_n++;
      if (cb1 < 1 || cb1 > 3) $display("FAIL single_count_b got %0d want 2+-1", cb1);
      else pass_n++;
      total_n++;
      if ({r1, t1} !== 2'b10) $display("FAIL single_resp_tie got %b want 10", {r1, t1});
      else pass_n++;
      total_n++;
      if (nv !== 1) $display("FAIL single_valid_pulses got %0d want 1", nv);
      else pass_n++;
      total_n++;
      if (ba !== 1'b0) $display("FAIL single_busy_after got %b want 0", ba);
      else pass_n++;
   endtask
   task automatic test_wrap;
      int lat, nv;
      logic ba;
      logic [7:0] es, ec;
      set_per(4, 4, 8, 4, 8, 4, 8, 8);
      run_eval(1, 3'd7, 10'd32, 0, lat, nv, ba, es, ec);
      total_n++;
      if (lat !== 149) $display("FAIL wrap_latency got %0d want 149", lat);
      else pass_n++;
      total_n++;
      if (es !== 8'b1000_0001) $display("FAIL wrap_en_bit0 got %b want 10000001", es);
      else pass_n++;
      total_n++;
      if (r4 !== 4'b1110) $display("FAIL wrap_resp got %b want 1110", r4);
      else pass_n++;
      total_n++;
      if (t4 !== 4'b0000) $display("FAIL wrap_tie got %b want 0000", t4);
      else pass_n++;
   endtask
   task automatic test_saturation;
      int lat, nv;
      logic ba;
      logic [7:0] es, ec;
      set_per(0, 0, 4, 4, 0, 0, 0, 0);
      run_eval(0, 3'd2, 10'd100, 0, lat, nv, ba, es, ec);
      total_n++;
      if (lat !== 106) $display("FAIL sat_latency got %0d want 106", lat);
      else pass_n++;
      total_n++;
      if ({ca1, cb1} !== 8'hFF) $display("FAIL sat_counts got %0d/%0d want 15/15", ca1, cb1);
      else pass_n++;
      total_n++;
      if ({r1, t1} !== 2'b01) $display("FAIL sat_resp_tie got %b want 01", {r1, t1});
      else pass_n++;
   endtask
   task automatic test_window_zero;
      int lat, nv;
      logic ba;
      logic [7:0] es, ec;
      set_per(4, 8, 4, 8, 4, 8, 4, 8);
      run_eval(1, 3'd0, 10'd0, 5, lat, nv, ba, es, ec);
      total_n++;
      if (lat !== 25) $display("FAIL win0_latency got %0d want 25", lat);
      else pass_n++;
      total_n++;
      if (nv !== 1) $display("FAIL win0_valid_pulses got %0d want 1", nv);
      else pass_n++;
      total_n++;
      if (ba !== 1'b0) $display("FAIL win0_busy_after got %b want 0", ba);
      else pass_n++;
   endtask
   task automatic test_reset_mid;
      int lat, nv;
      logic ba;
      logic [7:0] es, ec;
      set_per(4, 8, 8, 4, 4, 8, 8, 4);
      sel = 2;
      @(negedge clk);
      challenge = 3'd0;
      window = 10'd16;
      st[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      st[2] = 1'b0;
      for (int c = 2; c <= 50; c++) begin
         @(negedge clk);
         if (c == 49) begin
            total_n++;
            if ({b8, r8[0]} !== 2'b11) $display("FAIL mid_pre_reset got busy/resp0 %b want 11", {b8, r8[0]});
            else pass_n++;
         end
      end
      rst_n = 1'b1;
      #1;
      total_n++;
      if ({b8, v8, en8, r8, t8, ca8, cb8} !== '0) $display("FAIL mid_reset_outputs got %h want 0", {b8, v8, en8, r8, t8, ca8, cb8});
      else pass_n++;
      nv = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (v8 === 1'b1) nv++;
      end
      total_n++;
      if (nv !== 0) $display("FAIL mid_no_valid got %0d want 0", nv);
      else pass_n++;
      run_eval(2, 3'd0, 10'd16, 0, lat, nv, ba, es, ec);
      total_n++;
      if (lat !== 169) $display("FAIL mid_restart_latency got %0d want 169", lat);
      else pass_n++;
      total_n++;
      if (nv !== 1) $display("FAIL mid_restart_pulses got %0d want 1", nv);
      else pass_n++;
      total_n++;
      if ({r8, t8} !== 16'h5500) $display("FAIL mid_restart_resp_tie got %h want 5500", {r8, t8});
      else pass_n++;
   endtask
   initial begin
      for (int i = 0; i < 8; i++) per[i] = 0;
      test_reset;
      test_single_bit;
      test_wrap;
      test_saturation;
      test_window_zero;
      test_reset_mid;
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
